// File: rtl/zacore_decode.sv
// zacore_decode: RV32I decode stage with a 32x32 register file, writeback
// bypass, load-use hazard detection and a single output register stage.
// Optional feature macro: ZACORE_DECODE_RVM_EN. When it is defined, OP
// encodings with funct7=0000001 decode as MULDIV; otherwise they are ILLEGAL.
module zacore_decode (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fd_valid,
    input  logic [31:0] i_fd_inst,
    input  logic [31:0] i_fd_pc,
    input  logic        i_stall,
    input  logic        i_invalidate,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_stall,
    output logic        o_de_valid,
    output logic [31:0] o_de_pc,
    output logic [3:0]  o_de_op,
    output logic [2:0]  o_de_funct3,
    output logic        o_de_alt,
    output logic [4:0]  o_de_rd,
    output logic [31:0] o_de_rs1_val,
    output logic [31:0] o_de_rs2_val,
    output logic [31:0] o_de_imm
);

    localparam logic [3:0] OP_ALU_REG = 4'd0;
    localparam logic [3:0] OP_ALU_IMM = 4'd1;
    localparam logic [3:0] OP_LOAD    = 4'd2;
    localparam logic [3:0] OP_STORE   = 4'd3;
    localparam logic [3:0] OP_BRANCH  = 4'd4;
    localparam logic [3:0] OP_JAL     = 4'd5;
    localparam logic [3:0] OP_JALR    = 4'd6;
    localparam logic [3:0] OP_LUI     = 4'd7;
    localparam logic [3:0] OP_AUIPC   = 4'd8;
    localparam logic [3:0] OP_FENCE   = 4'd9;
    localparam logic [3:0] OP_SYSTEM  = 4'd10;
`ifdef ZACORE_DECODE_RVM_EN
    localparam logic [3:0] OP_MULDIV  = 4'd11;
`endif
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    // Immediate extraction, all sign-extended from inst[31].
    function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    logic [31:0]        rf [32];

    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [3:0]         dec_op;
    logic [4:0]         dec_rd;
    logic signed [31:0] dec_imm;
    logic               use_rs1;
    logic               use_rs2;
    logic [31:0]        rs1_val;
    logic [31:0]        rs2_val;
    logic               hazard;

    logic               vld_p1;
    logic [31:0]        pc_p1;
    logic [3:0]         op_p1;
    logic [2:0]         funct3_p1;
    logic               alt_p1;
    logic [4:0]         rd_p1;
    logic [31:0]        rs1_val_p1;
    logic [31:0]        rs2_val_p1;
    logic signed [31:0] imm_p1;

    assign rs1 = i_fd_inst[19:15];
    assign rs2 = i_fd_inst[24:20];

    // Classify the incoming instruction, pick its immediate and the operands it reads.
    always_comb begin
        dec_op  = OP_ILLEGAL;
        dec_imm = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (i_fd_inst[1:0] == 2'b11) begin
            case (i_fd_inst[6:2])
                5'b01100: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    if (i_fd_inst[31:25] == 7'b0000000 ||
                        (i_fd_inst[31:25] == 7'b0100000 &&
                         (i_fd_inst[14:12] == 3'd0 || i_fd_inst[14:12] == 3'd5)))
                        dec_op = OP_ALU_REG;
`ifdef ZACORE_DECODE_RVM_EN
                    else if (i_fd_inst[31:25] == 7'b0000001)
                        dec_op = OP_MULDIV;
`endif
                end
                5'b00100: begin dec_op = OP_ALU_IMM; dec_imm = imm_i(i_fd_inst); use_rs1 = 1'b1; end
                5'b00000: begin dec_op = OP_LOAD;    dec_imm = imm_i(i_fd_inst); use_rs1 = 1'b1; end
                5'b01000: begin
                    dec_op  = OP_STORE;
                    dec_imm = imm_s(i_fd_inst);
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                5'b11000: begin
                    dec_op  = OP_BRANCH;
                    dec_imm = imm_b(i_fd_inst);
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                5'b11011: begin dec_op = OP_JAL;    dec_imm = imm_j(i_fd_inst); end
                5'b11001: begin dec_op = OP_JALR;   dec_imm = imm_i(i_fd_inst); use_rs1 = 1'b1; end
                5'b01101: begin dec_op = OP_LUI;    dec_imm = imm_u(i_fd_inst); end
                5'b00101: begin dec_op = OP_AUIPC;  dec_imm = imm_u(i_fd_inst); end
                5'b00011: begin dec_op = OP_FENCE;  dec_imm = imm_i(i_fd_inst); end
                5'b11100: begin dec_op = OP_SYSTEM; dec_imm = imm_i(i_fd_inst); end
                default:  dec_op = OP_ILLEGAL;
            endcase
        end
        // An illegal word reads nothing, so it can never create a load-use stall.
        if (dec_op == OP_ILLEGAL) begin
            dec_imm = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
        if (dec_op == OP_STORE || dec_op == OP_BRANCH || dec_op == OP_ILLEGAL)
            dec_rd = 5'd0;
        else
            dec_rd = i_fd_inst[11:7];
    end

    // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
    always_comb begin
        rs1_val = rf[rs1];
        rs2_val = rf[rs2];
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (i_wb_en && i_wb_rd == rs1)
            rs1_val = i_wb_data;
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (i_wb_en && i_wb_rd == rs2)
            rs2_val = i_wb_data;
    end

    // Load-use hazard: the load in the output register has not produced its data yet.
    always_comb begin
        hazard = vld_p1 && (op_p1 == OP_LOAD) && (rd_p1 != 5'd0) && i_fd_valid &&
                 ((use_rs1 && rs1 == rd_p1) || (use_rs2 && rs2 == rd_p1));
    end

    assign o_stall = i_stall | hazard;

    // Register file: x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (i_wb_en && i_wb_rd != 5'd0) begin
            rf[i_wb_rd] <= i_wb_data;
        end
    end

    // ---- stage p1: decode output register ----
    // Flush beats hold, hold beats bubble, bubble beats accept.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            op_p1      <= '0;
            funct3_p1  <= '0;
            alt_p1     <= 1'b0;
            rd_p1      <= '0;
            rs1_val_p1 <= '0;
            rs2_val_p1 <= '0;
            imm_p1     <= '0;
        end else if (i_invalidate) begin
            vld_p1 <= 1'b0;
        end else if (!i_stall) begin
            if (hazard || !i_fd_valid) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1     <= 1'b1;
                pc_p1      <= i_fd_pc;
                op_p1      <= dec_op;
                funct3_p1  <= i_fd_inst[14:12];
                alt_p1     <= i_fd_inst[30];
                rd_p1      <= dec_rd;
                rs1_val_p1 <= rs1_val;
                rs2_val_p1 <= rs2_val;
                imm_p1     <= dec_imm;
            end
        end
    end

    assign o_de_valid   = vld_p1;
    assign o_de_pc      = pc_p1;
    assign o_de_op      = op_p1;
    assign o_de_funct3  = funct3_p1;
    assign o_de_alt     = alt_p1;
    assign o_de_rd      = rd_p1;
    assign o_de_rs1_val = rs1_val_p1;
    assign o_de_rs2_val = rs2_val_p1;
    assign o_de_imm     = imm_p1;

endmodule
